// File: rtl/aes_const.sv
// Shared AES sizing helpers, expansion FSM state type and the round-constant table.
package aes_const;

  localparam int NB     = 4;
  localparam int NK_DEF = 4;

  localparam logic [7:0] RCON [11] = '{
    8'h8d, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  typedef enum logic {S_IDLE, S_RUN} state_t;

  function automatic int nr_of(input int nk);
    return nk + 6;
  endfunction

  function automatic int nw_of(input int nk);
    return NB * (nr_of(nk) + 1);
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

endpackage

// File: rtl/aes_array.sv
// Constant AES tables built from GF(2^8) arithmetic: powers of 3, their logs,
// S-box (inverse via exp/log then affine map), inverse S-box and Rcon.
module aes_array
  import aes_const::*;
(
  output logic [7:0] s_box [256],
  output logic [7:0] i_box [256],
  output logic [7:0] r_con [11]
);

  logic [7:0] exp_3 [256];
  logic [7:0] ln_3  [256];

  always_comb begin : build_exp
    logic [7:0] acc;
    acc = 8'h01;
    for (int k = 0; k < 256; k++) begin
      exp_3[k] = acc;
      acc = xtime(acc) ^ acc;
    end
  end

  // 3 generates the whole multiplicative group, so k < 255 covers every nonzero value.
  always_comb begin
    ln_3 = '{default: 8'h00};
    for (int k = 0; k < 255; k++) begin
      ln_3[exp_3[k]] = 8'(k);
    end
  end

  always_comb begin : build_sbox
    logic [7:0] inv;
    inv = 8'h00;
    for (int a = 0; a < 256; a++) begin
      inv = (a == 0) ? 8'h00 : exp_3[8'd255 - ln_3[8'(a)]];
      s_box[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  end

  always_comb begin
    i_box = '{default: 8'h00};
    for (int a = 0; a < 256; a++) begin
      i_box[s_box[a]] = 8'(a);
    end
  end

  assign r_con = RCON;

endmodule

// File: rtl/aes_key_expand.sv
// Sequential AES key schedule: loads Nk key words on start, then derives one
// round-key word per cycle; done pulses one cycle after the last word lands.
module aes_key_expand
  import aes_const::*;
#(
  parameter int  Nk = NK_DEF,
  localparam int Nr = nr_of(Nk),
  localparam int NW = NB * (Nr + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [32*Nk-1:0]  key_in,
  input  logic [127:0]      data_in,
  output logic              busy,
  output logic              done,
  output logic              valid,
  output logic [32*NW-1:0]  kexp,
  output logic [127:0]      data_out
);

  localparam logic [5:0] NK_W     = 6'(Nk);
  localparam logic [5:0] NW_W     = 6'(NW);
  localparam logic [2:0] POS_LAST = 3'(Nk - 1);

  state_t      state, state_nxt;
  logic [5:0]  idx;
  logic [2:0]  pos;
  logic [3:0]  rnd;
  logic [31:0] w [NW];
  logic        accept, last;
  logic [31:0] prev, sub_in, sub_out, temp, word_nxt;
  logic [7:0]  s_box [256];
  logic [7:0]  i_box [256];
  logic [7:0]  r_con [11];

  aes_array u_tables (
    .s_box (s_box),
    .i_box (i_box),
    .r_con (r_con)
  );

  assign accept = start && !busy;
  assign last   = (idx == NW_W);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start)     state_nxt = S_RUN;
      S_RUN:   if (last)      state_nxt = S_IDLE;
      default:                state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == S_RUN);
  end

  // pos tracks i mod Nk and rnd tracks i / Nk, so no divider is needed.
  always_comb begin
    prev    = w[idx - 6'd1];
    sub_in  = (pos == 3'd0) ? {prev[23:0], prev[31:24]} : prev;
    sub_out = {s_box[sub_in[31:24]], s_box[sub_in[23:16]],
               s_box[sub_in[15:8]],  s_box[sub_in[7:0]]};
    if (pos == 3'd0)                 temp = sub_out ^ {r_con[rnd], 24'h0};
    else if (Nk == 8 && pos == 3'd4) temp = sub_out;
    else                             temp = prev;
    word_nxt = w[idx - NK_W] ^ temp;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      done     <= 1'b0;
      valid    <= 1'b0;
      idx      <= '0;
      pos      <= '0;
      rnd      <= '0;
      data_out <= '0;
      for (int j = 0; j < NW; j++) w[j] <= '0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        for (int j = 0; j < Nk; j++) w[j] <= key_in[32*Nk-1-32*j -: 32];
        data_out <= data_in;
        idx      <= NK_W;
        pos      <= 3'd0;
        rnd      <= 4'd1;
        valid    <= 1'b0;
      end else if (busy && !last) begin
        w[idx] <= word_nxt;
        idx    <= idx + 6'd1;
        if (pos == POS_LAST) begin
          pos <= 3'd0;
          rnd <= rnd + 4'd1;
        end else begin
          pos <= pos + 3'd1;
        end
      end else if (busy) begin
        done  <= 1'b1;
        valid <= 1'b1;
      end
    end
  end

  for (genvar g = 0; g < NW; g++) begin : g_kexp
    assign kexp[32*NW-1-32*g -: 32] = w[g];
  end

  a_sbox_bijective: assert property (@(posedge clk) disable iff (rst)
    (busy && !last) |-> (i_box[sub_out[7:0]] == sub_in[7:0]));

endmodule

// File: tb/tb_aes_key_expand.sv
// Scoreboard bench for aes_key_expand at all three key sizes against a FIPS-197 reference model.
module tb_aes_key_expand;

  typedef struct packed {
    logic [1919:0] w;
    logic [127:0]  d;
    logic [31:0]   due;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          start [3];
  logic [127:0]  din   [3];
  logic          busy  [3];
  logic          done  [3];
  logic          valid [3];
  logic [127:0]  dout  [3];
  logic [127:0]  key4;
  logic [191:0]  key6;
  logic [255:0]  key8;
  logic [1407:0] kx4;
  logic [1663:0] kx6;
  logic [1919:0] kx8;

  exp_t sbq [3][$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  logic [7:0] tb_sbox [256];

  logic [127:0] srow [16] = '{
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  aes_key_expand #(.Nk(4)) u_k128 (
    .clk(clk), .rst(rst), .start(start[0]), .key_in(key4), .data_in(din[0]),
    .busy(busy[0]), .done(done[0]), .valid(valid[0]), .kexp(kx4), .data_out(dout[0]));
  aes_key_expand #(.Nk(6)) u_k192 (
    .clk(clk), .rst(rst), .start(start[1]), .key_in(key6), .data_in(din[1]),
    .busy(busy[1]), .done(done[1]), .valid(valid[1]), .kexp(kx6), .data_out(dout[1]));
  aes_key_expand #(.Nk(8)) u_k256 (
    .clk(clk), .rst(rst), .start(start[2]), .key_in(key8), .data_in(din[2]),
    .busy(busy[2]), .done(done[2]), .valid(valid[2]), .kexp(kx8), .data_out(dout[2]));

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int nk_of(input int s);
    return 4 + 2 * s;
  endfunction

  function automatic int lat_of(input int s);
    case (s)
      0:       return 41;
      1:       return 47;
      default: return 53;
    endcase
  endfunction

  function automatic logic [1919:0] kx_of(input int s);
    case (s)
      0:       return {kx4, 512'b0};
      1:       return {kx6, 256'b0};
      default: return kx8;
    endcase
  endfunction

  function automatic logic [31:0] wd(input logic [1919:0] v, input int i);
    return v[1919-32*i -: 32];
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] x);
    return {tb_sbox[x[31:24]], tb_sbox[x[23:16]], tb_sbox[x[15:8]], tb_sbox[x[7:0]]};
  endfunction

  function automatic logic [1919:0] model(input int nk, input logic [255:0] k);
    logic [31:0]   w [60];
    logic [7:0]    rc [11];
    logic [31:0]   t;
    logic [1919:0] r;
    int nw;
    rc = '{8'h8d, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
    nw = 4 * (nk + 7);
    for (int i = 0; i < 60; i++) w[i] = '0;
    for (int i = 0; i < nk; i++) w[i] = k[255-32*i -: 32];
    for (int i = nk; i < nw; i++) begin
      t = w[i-1];
      if (i % nk == 0)                 t = subw({t[23:0], t[31:24]}) ^ {rc[i/nk], 24'h0};
      else if (nk == 8 && i % nk == 4) t = subw(t);
      w[i] = w[i-nk] ^ t;
    end
    r = '0;
    for (int i = 0; i < nw; i++) r[1919-32*i -: 32] = w[i];
    return r;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp_v);
    n_tests++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp_v);
    end
  endtask

  task automatic chk_sched(input string name, input logic [1919:0] act, input logic [1919:0] exp_v);
    int bad;
    bad = -1;
    n_tests++;
    for (int i = 59; i >= 0; i--) if (wd(act, i) !== wd(exp_v, i)) bad = i;
    if (bad >= 0) begin
      n_fail++;
      $display("FAIL %s: w[%0d] got %h expected %h", name, bad, wd(act, bad), wd(exp_v, bad));
    end
  endtask

  task automatic set_key(input int s, input logic [255:0] k);
    case (s)
      0:       key4 = k[255:128];
      1:       key6 = k[255:64];
      default: key8 = k;
    endcase
  endtask

  // Called at a negedge; leaves start high for exactly one rising edge.
  task automatic issue(input int s, input logic [255:0] k, input logic [127:0] d);
    exp_t e;
    start[s] = 1'b1;
    set_key(s, k);
    din[s] = d;
    e.w   = model(nk_of(s), k);
    e.d   = d;
    e.due = 32'(cyc + 1 + lat_of(s));
    sbq[s].push_back(e);
    @(negedge clk);
    start[s] = 1'b0;
  endtask

  task automatic wait_done(input int s, input int budget);
    int n;
    n = 0;
    while (!done[s] && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!done[s]) begin
      n_tests++;
      n_fail++;
      $display("FAIL done_timeout: size %0d got no done within %0d cycles", s, budget);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst) begin
      for (int s = 0; s < 3; s++) begin
        if (done[s]) begin
          if (sbq[s].size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_done: size %0d got done with empty scoreboard", s);
          end else begin
            e = sbq[s].pop_front();
            chk_sched("schedule", kx_of(s), e.w);
            chk("data_out", dout[s], e.d);
            chk("valid_at_done", 128'(valid[s]), 128'd1);
            chk("busy_at_done", 128'(busy[s]), 128'd0);
            chk("latency", 128'(cyc), 128'(e.due));
          end
        end
      end
    end
  end

  logic [255:0] kv [3];
  logic [31:0]  w_first [3];
  logic [31:0]  w_last [3];
  logic [255:0] rk;
  logic [127:0] rd;
  int bad;

  initial begin
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++) tb_sbox[16*r+c] = srow[r][127-8*c -: 8];
    kv[0] = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    kv[1] = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
    kv[2] = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    w_first = '{32'ha0fafe17, 32'hfe0c91f7, 32'h9ba35411};
    w_last  = '{32'hb6630ca6, 32'h01002202, 32'h706c631e};

    rst = 1'b1;
    key4 = '0; key6 = '0; key8 = '0;
    for (int s = 0; s < 3; s++) begin
      start[s] = 1'b0;
      din[s] = '0;
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    for (int s = 0; s < 3; s++) begin
      chk("reset_busy", 128'(busy[s]), 128'd0);
      chk("reset_done", 128'(done[s]), 128'd0);
      chk("reset_valid", 128'(valid[s]), 128'd0);
      chk_sched("reset_kexp", kx_of(s), '0);
      chk("reset_data", dout[s], 128'd0);
    end

    chk("sbox_00", 128'(u_k128.u_tables.s_box[8'h00]), 128'h63);
    chk("sbox_53", 128'(u_k128.u_tables.s_box[8'h53]), 128'hed);
    chk("ibox_63", 128'(u_k128.u_tables.i_box[8'h63]), 128'h00);
    chk("exp3_01", 128'(u_k128.u_tables.exp_3[8'h01]), 128'h03);
    chk("ln3_03", 128'(u_k128.u_tables.ln_3[8'h03]), 128'h01);
    chk("rcon_10", 128'(u_k128.u_tables.r_con[10]), 128'h36);
    bad = 0;
    for (int a = 0; a < 256; a++) if (u_k128.u_tables.s_box[a] !== tb_sbox[a]) bad++;
    chk("sbox_all_bad_entries", 128'(bad), 128'd0);
    bad = 0;
    for (int a = 0; a < 256; a++) if (u_k128.u_tables.i_box[tb_sbox[a]] !== 8'(a)) bad++;
    chk("ibox_all_bad_entries", 128'(bad), 128'd0);

    for (int s = 0; s < 3; s++) begin
      issue(s, kv[s], 128'h3243f6a8885a308d313198a2e0370734);
      wait_done(s, 80);
      chk("known_first_word", 128'(wd(kx_of(s), nk_of(s))), 128'(w_first[s]));
      chk("known_last_word", 128'(wd(kx_of(s), 4 * (nk_of(s) + 7) - 1)), 128'(w_last[s]));
      chk("data_byte0", 128'(dout[s][127:120]), 128'h32);
      chk("data_byte15", 128'(dout[s][7:0]), 128'h34);
      @(negedge clk);
      chk("valid_held", 128'(valid[s]), 128'd1);
      chk("done_one_cycle", 128'(done[s]), 128'd0);
    end

    for (int s = 0; s < 3; s++) begin
      for (int n = 0; n < 6; n++) begin
        if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge clk);
        rk = {$urandom(), $urandom(), $urandom(), $urandom(),
              $urandom(), $urandom(), $urandom(), $urandom()};
        rd = {$urandom(), $urandom(), $urandom(), $urandom()};
        issue(s, rk, rd);
        if (n % 2 == 1) begin
          repeat (10) @(negedge clk);
          start[s] = 1'b1;
          set_key(s, ~rk);
          din[s] = ~rd;
          @(negedge clk);
          start[s] = 1'b0;
        end
        wait_done(s, 80);
      end
    end

    @(negedge clk);
    issue(2, kv[2], 128'h0123456789abcdef0123456789abcdef);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    for (int s = 0; s < 3; s++) sbq[s].delete();
    @(negedge clk);
    chk("abort_busy", 128'(busy[2]), 128'd0);
    chk("abort_valid", 128'(valid[2]), 128'd0);
    chk("abort_done", 128'(done[2]), 128'd0);
    chk_sched("abort_kexp", kx_of(2), '0);
    chk("abort_other_valid", 128'(valid[0]), 128'd0);
    rst = 1'b0;
    @(negedge clk);
    issue(2, kv[2], 128'h3243f6a8885a308d313198a2e0370734);
    wait_done(2, 80);

    repeat (3) @(negedge clk);
    for (int s = 0; s < 3; s++) chk("scoreboard_drained", 128'(sbq[s].size()), 128'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/aes_key_expand.md
# aes_key_expand

Sequential AES key-schedule engine with byte formatting of the input block. It expands a 128/192/256-bit cipher key into the full round-key word array, one word per clock, using the FIPS-197 KeyExpansion algorithm. It also latches the 128-bit data block as 16 bytes. It sits between the key/data input registers and the round datapath, and owns the S-box, inverse S-box, GF(2^8) exp/log and Rcon constant tables.

## Interface
- Nk, default 4: key length in 32-bit words; legal values are 4, 6 and 8.
- Nb, fixed 4: block size in words.
- Nr, derived as Nk+6: number of rounds.
- NW, derived as Nb*(Nr+1): round-key words (44/52/60).
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request a new expansion; ignored while busy.
- key_in  in  32*Nk  cipher key; word 0 = most-significant 32 bits.
- data_in  in  128  plaintext/ciphertext block.
- busy  out  1  expansion in progress.
- done  out  1  single-cycle pulse when the last word is written.
- valid  out  1  kexp holds a complete schedule; held until the next accepted start.
- kexp  out  NW x 32  round-key words w[0..NW-1].
- data_out  out  16 x 8  data bytes; byte i = data_in[127-8i -: 8], captured on an accepted start.

## Operation
- Accept rule: start is accepted when start=1 and busy=0 at a rising edge.
- On accept:
  - w[j] = key_in[32*Nk-1-32j -: 32] for j < Nk.
  - Capture data_out.
  - Set index i = Nk and busy=1; clear valid.
- Each busy cycle computes w[i] = w[i-Nk] ^ temp, where temp = w[i-1] modified as follows:
  - i mod Nk == 0: temp = SubWord(RotWord(w[i-1])) ^ {Rcon[i/Nk], 24'h0}.
  - Nk == 8 and i mod Nk == 4: temp = SubWord(w[i-1]).
  - Otherwise temp is w[i-1] unchanged.
- RotWord: {b1,b2,b3,b0}. SubWord applies the S-box to each byte.
- Rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36; Rcon[0] = 8d.
- After writing w[NW-1]: busy=0, valid=1, done pulses for one cycle.
- Words not yet computed keep their previous value. Only the valid=1 state guarantees a full schedule.
- Tables: S-box and inverse S-box per FIPS-197. EXP3[k] = 3^k in GF(2^8) with polynomial 11b. LN3 is its inverse log, with LN3[0] = 0.

## Timing
- Reset values: busy=0, done=0, valid=0, all kexp words 0, all data_out bytes 0, i=0.
- Reset takes priority over start and over an expansion in progress (aborts it; valid stays 0).
- Latency from the accept edge to the edge at which done goes high: 1 + (NW-Nk) cycles.
  - AES-128: 41 cycles.
  - AES-192: 47 cycles.
  - AES-256: 53 cycles.
- Words w[0..Nk-1] are visible the cycle after accept. Word w[i] is visible the cycle after it is computed.
- start during busy is ignored; there is no queueing.
- start in the same cycle done is high is accepted (busy is already 0).
- key_in is sampled only at accept and may change afterwards.
- data_in is sampled only at accept.

## Structure
- Package aes_const: Nb, Nk, Nr, NW, and the Rcon table.
- Sub-module aes_array: purely combinational constant tables S_Box, I_Box, EXP_3, LN_3 and R_Con, each an array of 8-bit entries, instantiated once.
- SubWord uses four S-box lookups from aes_array; no other multiplier logic is needed.
- The remainder is one sequential module containing the index counter, the word-register array and the data byte register.

## Test plan
- AES-128, key 2b7e151628aed2a6abf7158809cf4f3c, start: w[4]=a0fafe17, w[43]=b6630ca6, done after 41 cycles, valid=1.
- AES-192 (Nk=6), key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b: w[6]=fe0c91f7, w[51]=01002202, done after 47 cycles.
- AES-256 (Nk=8), key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4: w[8]=9ba35411, w[59]=706c631e, done after 53 cycles.
- data_in 3243f6a8885a308d313198a2e0370734 with start: data_out[0]=32, data_out[15]=34.
- start pulsed again mid-expansion is ignored and the final words are unchanged. rst asserted mid-expansion gives busy=0, valid=0, kexp all 0 on the next cycle.
- Table spot checks:
  - S_Box[00]=63, S_Box[53]=ed.
  - I_Box[63]=00.
  - EXP_3[01]=03.
  - LN_3[03]=01.
  - R_Con[10]=36.
